// File: rtl/fft_frame_streamer_if.sv
// Output beat stream of fft_frame_streamer: valid/ready handshake with
// 16 I/Q lanes per beat plus the beat index and end-of-frame flag.
//   master : producer side (drives valid, lanes, beat, last; samples ready)
//   slave  : consumer side (samples the beat, drives ready)
interface fft_frame_streamer_if #(
    parameter int unsigned W      = 13,
    parameter int unsigned LANES  = 16,
    parameter int unsigned BEAT_W = 5
);
    logic                        dout_valid;
    logic                        dout_ready;
    logic [LANES-1:0][W-1:0]     dout_i;
    logic [LANES-1:0][W-1:0]     dout_q;
    logic [BEAT_W-1:0]           dout_beat;
    logic                        dout_last;

    modport master (
        output dout_valid,
        output dout_i,
        output dout_q,
        output dout_beat,
        output dout_last,
        input  dout_ready
    );

    modport slave (
        input  dout_valid,
        input  dout_i,
        input  dout_q,
        input  dout_beat,
        input  dout_last,
        output dout_ready
    );
endinterface

// File: rtl/fft_frame_streamer.sv
// Captures whole FFT frames (presented in parallel for one cycle) into a
// two-bank ping-pong buffer and replays each as N/LANES beats over a
// valid/ready stream. Frames arriving with both banks occupied are dropped.
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   frame_valid      one-cycle pulse, din_i/din_q hold a complete frame
//   din_i, din_q     N samples of W bits, index 0 = first sample
//   dout             beat stream (master side), all fields registered
//   overflow         sticky flag, set on the first dropped frame
//   drop_count       dropped-frame count, saturating
module fft_frame_streamer #(
    parameter int unsigned N     = 512,
    parameter int unsigned LANES = 16,
    parameter int unsigned W     = 13,
    parameter int unsigned CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  frame_valid,
    input  logic [N-1:0][W-1:0]   din_i,
    input  logic [N-1:0][W-1:0]   din_q,
    fft_frame_streamer_if.master  dout,
    output logic                  overflow,
    output logic [CNT_W-1:0]      drop_count
);
    localparam int unsigned BEATS  = N / LANES;
    localparam int unsigned BEAT_W = $clog2(BEATS);
    localparam int unsigned LANE_W = $clog2(LANES);
    localparam int unsigned ADDR_W = $clog2(N);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    // Sample storage, no reset: contents only matter once the bank is full.
    logic [N-1:0][W-1:0] bank_i [2];
    logic [N-1:0][W-1:0] bank_q [2];

    logic [1:0]          full;
    logic                wr_sel;
    logic                rd_sel;
    logic [BEAT_W-1:0]   beat;

    logic                xfer;
    logic                rel;
    logic                cap;
    logic                drop;
    logic [1:0]          full_rel;
    logic [1:0]          full_nxt;
    logic                wr_sel_nxt;
    logic                rd_sel_nxt;
    logic [BEAT_W-1:0]   beat_nxt;
    logic                valid_nxt;
    logic                last_nxt;
    logic [ADDR_W-1:0]   rd_base;
    logic [LANES-1:0][W-1:0] lane_i_nxt;
    logic [LANES-1:0][W-1:0] lane_q_nxt;
    logic                overflow_nxt;
    logic [CNT_W-1:0]    drop_count_nxt;

    // Next-state and next-output computation.
    always_comb begin
        xfer           = full[rd_sel] && dout.dout_ready;
        rel            = xfer && (beat == LAST_BEAT);
        full_rel       = full;
        full_nxt       = full;
        wr_sel_nxt     = wr_sel;
        rd_sel_nxt     = rd_sel;
        beat_nxt       = beat;
        overflow_nxt   = overflow;
        drop_count_nxt = drop_count;
        lane_i_nxt     = '0;
        lane_q_nxt     = '0;

        // A bank released by its final beat is writable in the same cycle.
        if (rel) begin
            full_rel[rd_sel] = 1'b0;
        end
        cap  = frame_valid && !full_rel[wr_sel];
        drop = frame_valid &&  full_rel[wr_sel];

        full_nxt = full_rel;
        if (cap) begin
            full_nxt[wr_sel] = 1'b1;
            wr_sel_nxt       = ~wr_sel;
        end
        if (rel) begin
            rd_sel_nxt = ~rd_sel;
        end
        if (xfer) begin
            beat_nxt = rel ? '0 : beat + 1'b1;
        end

        if (drop) begin
            overflow_nxt = 1'b1;
            if (drop_count != CNT_MAX) begin
                drop_count_nxt = drop_count + 1'b1;
            end
        end

        valid_nxt = full_nxt[rd_sel_nxt];
        last_nxt  = valid_nxt && (beat_nxt == LAST_BEAT);
        rd_base   = {beat_nxt, LANE_W'(0)};

        // Registered lanes: a bank being written this cycle is read from din.
        if (valid_nxt) begin
            if (cap && (wr_sel == rd_sel_nxt)) begin
                lane_i_nxt = din_i[rd_base +: LANES];
                lane_q_nxt = din_q[rd_base +: LANES];
            end else begin
                lane_i_nxt = bank_i[rd_sel_nxt][rd_base +: LANES];
                lane_q_nxt = bank_q[rd_sel_nxt][rd_base +: LANES];
            end
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            full            <= '0;
            wr_sel          <= 1'b0;
            rd_sel          <= 1'b0;
            beat            <= '0;
            overflow        <= 1'b0;
            drop_count      <= '0;
            dout.dout_valid <= 1'b0;
            dout.dout_i     <= '0;
            dout.dout_q     <= '0;
            dout.dout_beat  <= '0;
            dout.dout_last  <= 1'b0;
        end else begin
            full            <= full_nxt;
            wr_sel          <= wr_sel_nxt;
            rd_sel          <= rd_sel_nxt;
            beat            <= beat_nxt;
            overflow        <= overflow_nxt;
            drop_count      <= drop_count_nxt;
            dout.dout_valid <= valid_nxt;
            dout.dout_i     <= lane_i_nxt;
            dout.dout_q     <= lane_q_nxt;
            dout.dout_beat  <= beat_nxt;
            dout.dout_last  <= last_nxt;
        end
    end

    // Frame capture into the selected bank.
    always_ff @(posedge clk) begin
        if (cap) begin
            bank_i[wr_sel] <= din_i;
            bank_q[wr_sel] <= din_q;
        end
    end
endmodule

// File: tb/tb_fft_frame_streamer.sv
// Scoreboard bench for fft_frame_streamer: each accepted frame pushes its
// expected beats; a negedge monitor compares every presented beat.
module tb_fft_frame_streamer;
    localparam int unsigned N     = 512;
    localparam int unsigned LANES = 16;
    localparam int unsigned W     = 13;
    localparam int unsigned CNT_W = 8;

    typedef struct packed {
        logic [LANES-1:0][W-1:0] i;
        logic [LANES-1:0][W-1:0] q;
        logic [4:0]              beat;
        logic                    last;
    } beat_t;

    logic                clk = 1'b0;
    logic                rstn;
    logic                frame_valid;
    logic [N-1:0][W-1:0] din_i;
    logic [N-1:0][W-1:0] din_q;
    logic                overflow;
    logic [CNT_W-1:0]    drop_count;

    fft_frame_streamer_if #(.W(W), .LANES(LANES), .BEAT_W(5)) dif ();

    fft_frame_streamer #(.N(N), .LANES(LANES), .W(W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .frame_valid (frame_valid),
        .din_i       (din_i),
        .din_q       (din_q),
        .dout        (dif),
        .overflow    (overflow),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    beat_t sb[$];
    int    total = 0;
    int    bad   = 0;
    int    xfer_cnt = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compare presented beat with scoreboard head; pop on transfer.
    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            if (dif.dout_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL mon_unexpected act_beat=%0d exp=none t=%0t", dif.dout_beat, $time);
                end else begin
                    chk("mon_i",    256'(dif.dout_i),    256'(sb[0].i));
                    chk("mon_q",    256'(dif.dout_q),    256'(sb[0].q));
                    chk("mon_beat", 256'(dif.dout_beat), 256'(sb[0].beat));
                    chk("mon_last", 256'(dif.dout_last), 256'(sb[0].last));
                    if (dif.dout_ready === 1'b1) begin
                        void'(sb.pop_front());
                        xfer_cnt++;
                    end
                end
            end else begin
                chk("idle_zero", 256'({dif.dout_i, dif.dout_q, dif.dout_beat, dif.dout_last}), 256'(0));
            end
        end
    end

    // kind 0: I = n-256, Q = -n; other kinds: distinct arithmetic patterns.
    task automatic set_frame(input int kind);
        for (int n = 0; n < int'(N); n++) begin
            if (kind == 0) begin
                din_i[n] = W'(n - 256);
                din_q[n] = W'(-n);
            end else begin
                din_i[n] = W'(n * 37 + kind * 1001);
                din_q[n] = W'(kind * 523 - n * 11);
            end
        end
    endtask

    task automatic push_frame();
        beat_t e;
        for (int b = 0; b < 32; b++) begin
            e.i    = din_i[b*16 +: 16];
            e.q    = din_q[b*16 +: 16];
            e.beat = 5'(b);
            e.last = (b == 31);
            sb.push_back(e);
        end
    endtask

    // Issue one frame pulse; caller states whether it must be accepted.
    task automatic pulse(input int kind, input bit accept);
        set_frame(kind);
        frame_valid = 1'b1;
        if (accept) push_frame();
        @(posedge clk);
        #1;
        frame_valid = 1'b0;
    endtask

    task automatic drain(input string nm, input int budget);
        bit done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            if (sb.size() == 0 && dif.dout_valid === 1'b0) done = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk({nm, "_drained"}, 256'(done), 256'(1));
    endtask

    task automatic wait_beat(input int b, input string nm);
        bit found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            if (dif.dout_valid === 1'b1 && dif.dout_beat == 5'(b)) found = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk({nm, "_wait"}, 256'(found), 256'(1));
    endtask

    logic [W-1:0] exp_s;
    bit [3:0]     pat;
    int           x0;

    initial begin
        rstn = 1'b0;
        frame_valid = 1'b0;
        dif.dout_ready = 1'b0;
        din_i = '0;
        din_q = '0;
        #12;
        chk("rst_valid", 256'(dif.dout_valid), 256'(0));
        chk("rst_data",  256'({dif.dout_i, dif.dout_q}), 256'(0));
        chk("rst_beat_last", 256'({dif.dout_beat, dif.dout_last}), 256'(0));
        chk("rst_ovf_cnt", 256'({overflow, drop_count}), 256'(0));
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Single frame, ready high: beats 0..31 on consecutive cycles.
        dif.dout_ready = 1'b1;
        pulse(0, 1'b1);
        for (int k = 0; k < 32; k++) begin
            chk("single_valid", 256'(dif.dout_valid), 256'(1));
            chk("single_beat",  256'(dif.dout_beat), 256'(k));
            chk("single_last",  256'(dif.dout_last), 256'(k == 31));
            if (k == 5) begin
                exp_s = W'(-173);   // n = 16*5+3 = 83 -> I = 83-256
                chk("b5l3_i", 256'(dif.dout_i[3]), 256'(exp_s));
                exp_s = W'(-83);
                chk("b5l3_q", 256'(dif.dout_q[3]), 256'(exp_s));
            end
            @(posedge clk);
            #1;
        end
        chk("single_after", 256'(dif.dout_valid), 256'(0));
        drain("single", 10);

        // Backpressure: ready pattern 1,0,0,1 repeating.
        pat = 4'b1001;
        x0 = xfer_cnt;
        pulse(2, 1'b1);
        for (int c = 0; c < 300 && (sb.size() != 0 || dif.dout_valid === 1'b1); c++) begin
            dif.dout_ready = pat[c % 4];
            @(posedge clk);
            #1;
        end
        dif.dout_ready = 1'b1;
        drain("bp", 10);
        chk("bp_xfers", 256'(xfer_cnt - x0), 256'(32));

        // Back-to-back frames: no gap between A and B.
        pulse(3, 1'b1);
        pulse(4, 1'b1);
        for (int k = 1; k < 64; k++) begin
            chk("b2b_valid", 256'(dif.dout_valid), 256'(1));
            chk("b2b_beat",  256'(dif.dout_beat), 256'(k % 32));
            @(posedge clk);
            #1;
        end
        chk("b2b_after", 256'(dif.dout_valid), 256'(0));
        chk("b2b_nodrop", 256'({overflow, drop_count}), 256'(0));
        drain("b2b", 10);

        // Simultaneous release + capture on beat 31 of the oldest bank.
        dif.dout_ready = 1'b0;
        pulse(5, 1'b1);
        pulse(6, 1'b1);
        dif.dout_ready = 1'b1;
        wait_beat(31, "sim");
        pulse(7, 1'b1);
        chk("sim_nodrop", 256'({overflow, drop_count}), 256'(0));
        drain("sim", 200);

        // Overflow: both banks held, third frame dropped, then saturation.
        dif.dout_ready = 1'b0;
        pulse(8, 1'b1);
        pulse(9, 1'b1);
        pulse(10, 1'b0);
        chk("ovf_flag", 256'(overflow), 256'(1));
        chk("ovf_cnt1", 256'(drop_count), 256'(1));
        for (int d = 0; d < 300; d++) pulse(11 + (d % 5), 1'b0);
        chk("ovf_sat", 256'(drop_count), 256'(255));
        chk("ovf_sticky", 256'(overflow), 256'(1));
        dif.dout_ready = 1'b1;
        drain("ovf", 200);
        chk("ovf_keep", 256'({overflow, drop_count}), 256'({1'b1, 8'd255}));

        // Reset while beat 10 of a frame is presented.
        pulse(20, 1'b1);
        wait_beat(10, "rst");
        #2;
        rstn = 1'b0;
        sb.delete();
        #1;
        chk("mrst_valid", 256'(dif.dout_valid), 256'(0));
        chk("mrst_data",  256'({dif.dout_i, dif.dout_q}), 256'(0));
        chk("mrst_beat_last", 256'({dif.dout_beat, dif.dout_last}), 256'(0));
        chk("mrst_ovf_cnt", 256'({overflow, drop_count}), 256'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk("mrst_no_residual", 256'(dif.dout_valid), 256'(0));
        end
        pulse(21, 1'b1);
        chk("mrst_new_beat0", 256'({dif.dout_valid, dif.dout_beat}), 256'({1'b1, 5'd0}));
        drain("mrst", 60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1);
    end
endmodule
